// File: rtl/programmable_clock_divider_bank.sv
`default_nettype none
// ============================================================================
//  Module      : programmable_clock_divider_bank
//  Description : NUM_CHANNELS independent divided-clock generators driven by a
//                single fabric clock. Each channel takes a runtime divisor
//                through a valid/ready config port. Divisor changes are held
//                in a shadow register and applied only at a period boundary,
//                so the outputs never glitch. A global sync_start realigns all
//                running channels to the start of a period.
//  Revision    : 1.0 - initial release
// ============================================================================
module programmable_clock_divider_bank #(
  parameter int NUM_CHANNELS = 5,
  parameter int DIV_WIDTH    = 16,
  localparam int CH_WIDTH    = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [CH_WIDTH-1:0]     cfg_channel,
  input  logic [DIV_WIDTH-1:0]    cfg_divisor,
  input  logic                    cfg_enable,
  input  logic                    sync_start,
  output logic [NUM_CHANNELS-1:0] div_out,
  output logic [NUM_CHANNELS-1:0] active,
  output logic [NUM_CHANNELS-1:0] period_tick
);

  // Channel state encoding
  localparam logic [1:0] c_st_idle    = 2'd0;
  localparam logic [1:0] c_st_run     = 2'd1;
  localparam logic [1:0] c_st_pending = 2'd2;

  // Smallest legal divisor and a width-matched increment
  localparam logic [DIV_WIDTH-1:0] c_min_div = DIV_WIDTH'(2);
  localparam logic [DIV_WIDTH-1:0] c_one     = DIV_WIDTH'(1);

  // Channel count extended by one bit so that 2**CH_WIDTH channels still fits
  localparam logic [CH_WIDTH:0] c_num_ch = NUM_CHANNELS[CH_WIDTH:0];

  // Pending flags padded to every encodable channel index
  localparam int c_ch_slots = 1 << CH_WIDTH;

  logic [NUM_CHANNELS-1:0]   w_pending;
  logic [c_ch_slots-1:0]     w_pending_slots;
  logic                      w_in_range;
  logic                      w_ready;
  logic [DIV_WIDTH-1:0]      w_eff_div;

  // Pad the pending vector so an out-of-range index reads a defined zero
  always_comb begin
    w_pending_slots                 = '0;
    w_pending_slots[NUM_CHANNELS-1:0] = w_pending;
  end

  assign w_in_range = ({1'b0, cfg_channel} < c_num_ch);
  assign w_ready    = !reset && !sync_start && w_in_range && !w_pending_slots[cfg_channel];
  assign cfg_ready  = w_ready;

  // Divisors of 0 and 1 behave as 2
  assign w_eff_div = (cfg_divisor < c_min_div) ? c_min_div : cfg_divisor;

  for (genvar k = 0; k < NUM_CHANNELS; k++) begin : g_ch
    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic [DIV_WIDTH-1:0] r_count;
    logic [DIV_WIDTH-1:0] w_count_nxt;
    logic [DIV_WIDTH-1:0] r_div;
    logic [DIV_WIDTH-1:0] w_div_nxt;
    logic [DIV_WIDTH-1:0] r_shadow_div;
    logic [DIV_WIDTH-1:0] w_shadow_div_nxt;
    logic                 r_shadow_en;
    logic                 w_shadow_en_nxt;
    logic                 r_out;
    logic                 r_tick;
    logic                 w_out_nxt;
    logic                 w_tick_nxt;
    logic                 w_xfer;
    logic                 w_wrap;
    logic                 w_running_nxt;
    logic [DIV_WIDTH-1:0] w_half_nxt;

    assign w_xfer = cfg_valid && w_ready && (cfg_channel == CH_WIDTH'(k));
    assign w_wrap = (r_count == (r_div - c_one));

    // State and datapath registers, cleared immediately by reset
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        r_state      <= c_st_idle;
        r_count      <= '0;
        r_div        <= c_min_div;
        r_shadow_div <= c_min_div;
        r_shadow_en  <= 1'b0;
        r_out        <= 1'b0;
        r_tick       <= 1'b0;
      end else begin
        r_state      <= w_state_nxt;
        r_count      <= w_count_nxt;
        r_div        <= w_div_nxt;
        r_shadow_div <= w_shadow_div_nxt;
        r_shadow_en  <= w_shadow_en_nxt;
        r_out        <= w_out_nxt;
        r_tick       <= w_tick_nxt;
      end
    end

    // Next state: start from IDLE, wrap or restart at boundaries/sync, and
    // park new configs in the shadow until the next boundary
    always_comb begin
      w_state_nxt      = r_state;
      w_count_nxt      = r_count;
      w_div_nxt        = r_div;
      w_shadow_div_nxt = r_shadow_div;
      w_shadow_en_nxt  = r_shadow_en;
      case (r_state)
        c_st_idle: begin
          w_count_nxt = '0;
          if (w_xfer && cfg_enable) begin
            w_state_nxt = c_st_run;
            w_div_nxt   = w_eff_div;
          end
        end
        c_st_run, c_st_pending: begin
          if (sync_start || w_wrap) begin
            w_count_nxt = '0;
            if (r_state == c_st_pending) begin
              if (r_shadow_en) begin
                w_div_nxt   = r_shadow_div;
                w_state_nxt = c_st_run;
              end else begin
                w_state_nxt = c_st_idle;
              end
            end
          end else begin
            w_count_nxt = r_count + c_one;
          end
          // A transfer only reaches a RUN channel (pending blocks ready,
          // sync blocks ready), so the boundary above used the old config
          if (w_xfer) begin
            w_shadow_div_nxt = w_eff_div;
            w_shadow_en_nxt  = cfg_enable;
            w_state_nxt      = c_st_pending;
          end
        end
        default: begin
          w_state_nxt = c_st_idle;
          w_count_nxt = '0;
        end
      endcase
    end

    // Registered outputs derived from the upcoming count and divisor;
    // the high phase is ceil(D/2) so odd divisors favour high
    always_comb begin
      w_running_nxt = (w_state_nxt != c_st_idle);
      w_half_nxt    = (w_div_nxt >> 1) + {{(DIV_WIDTH-1){1'b0}}, w_div_nxt[0]};
      w_out_nxt     = w_running_nxt && (w_count_nxt < w_half_nxt);
      w_tick_nxt    = w_running_nxt && (w_count_nxt == '0);
    end

    assign div_out[k]     = r_out;
    assign period_tick[k] = r_tick;
    assign active[k]      = (r_state != c_st_idle);
    assign w_pending[k]   = (r_state == c_st_pending);
  end

endmodule
`default_nettype wire

// File: tb/tb_programmable_clock_divider_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_programmable_clock_divider_bank
//  Description : Self-checking bench for programmable_clock_divider_bank.
//                A cycle-level reference model predicts every channel's
//                outputs; predictions are queued when stimulus is driven and
//                compared after the following clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_programmable_clock_divider_bank;

  localparam int N = 5;

  logic          clock = 1'b0;
  logic          reset;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [2:0]    cfg_channel;
  logic [15:0]   cfg_divisor;
  logic          cfg_enable;
  logic          sync_start;
  logic [N-1:0]  div_out;
  logic [N-1:0]  active;
  logic [N-1:0]  period_tick;

  int errors = 0;
  int checks = 0;

  programmable_clock_divider_bank #(
    .NUM_CHANNELS(N),
    .DIV_WIDTH(16)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_channel(cfg_channel),
    .cfg_divisor(cfg_divisor),
    .cfg_enable (cfg_enable),
    .sync_start (sync_start),
    .div_out    (div_out),
    .active     (active),
    .period_tick(period_tick)
  );

  always #5 clock = ~clock;

  // Reference model state
  bit m_run  [N];
  int m_d    [N];
  int m_pos  [N];
  bit m_pend [N];
  bit m_pen  [N];
  int m_pd   [N];

  typedef struct {
    logic [N-1:0] o;
    logic [N-1:0] t;
    logic [N-1:0] a;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    logic        v;
    logic [2:0]  ch;
    logic [15:0] d;
    logic        e;
    logic        s;
    int          hold;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int clampd(input logic [15:0] d);
    return (d < 16'd2) ? 2 : int'(d);
  endfunction

  function automatic logic model_ready(input logic [2:0] ch, input logic s);
    if (s) return 1'b0;
    if (int'(ch) >= N) return 1'b0;
    return !m_pend[int'(ch)];
  endfunction

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      m_run[c] = 0; m_d[c] = 2; m_pos[c] = 0;
      m_pend[c] = 0; m_pen[c] = 0; m_pd[c] = 2;
    end
    sb.delete();
  endtask

  task automatic model_step(input logic v, input logic [2:0] ch, input logic [15:0] d,
                            input logic e, input logic s);
    logic xf;
    xf = v && model_ready(ch, s);
    for (int c = 0; c < N; c++) begin
      if (!m_run[c]) begin
        if (xf && int'(ch) == c && e) begin
          m_run[c] = 1; m_d[c] = clampd(d); m_pos[c] = 0;
        end
      end else begin
        if (s || m_pos[c] == m_d[c] - 1) begin
          m_pos[c] = 0;
          if (m_pend[c]) begin
            m_pend[c] = 0;
            if (m_pen[c]) m_d[c] = m_pd[c];
            else          m_run[c] = 0;
          end
        end else begin
          m_pos[c]++;
        end
        if (xf && int'(ch) == c) begin
          m_pend[c] = 1; m_pd[c] = clampd(d); m_pen[c] = e;
        end
      end
    end
  endtask

  function automatic exp_t model_outputs();
    exp_t r;
    for (int c = 0; c < N; c++) begin
      r.o[c] = m_run[c] && (m_pos[c] < (m_d[c] + 1) / 2);
      r.t[c] = m_run[c] && (m_pos[c] == 0);
      r.a[c] = m_run[c];
    end
    return r;
  endfunction

  // Called at posedge+1: drive, check ready, predict, clock, compare
  task automatic step_cycle(input logic v, input logic [2:0] ch, input logic [15:0] d,
                            input logic e, input logic s);
    exp_t got;
    cfg_valid = v; cfg_channel = ch; cfg_divisor = d; cfg_enable = e; sync_start = s;
    #1;
    check("cfg_ready", 32'(cfg_ready), 32'(model_ready(ch, s)));
    model_step(v, ch, d, e, s);
    sb.push_back(model_outputs());
    @(posedge clock);
    #1;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'(1), 32'(0));
    end else begin
      got = sb.pop_front();
      check("div_out", 32'(div_out), 32'(got.o));
      check("period_tick", 32'(period_tick), 32'(got.t));
      check("active", 32'(active), 32'(got.a));
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step_cycle(1'b0, 3'd0, 16'd0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] obs_out;
    logic [7:0] obs_tick;

    vecs[0]  = '{v:1'b1, ch:3'd1, d:16'd3,      e:1'b1, s:1'b0, hold:6};
    vecs[1]  = '{v:1'b1, ch:3'd2, d:16'd0,      e:1'b1, s:1'b0, hold:5};
    vecs[2]  = '{v:1'b1, ch:3'd0, d:16'd6,      e:1'b1, s:1'b0, hold:0};
    vecs[3]  = '{v:1'b1, ch:3'd0, d:16'd8,      e:1'b1, s:1'b0, hold:14};
    vecs[4]  = '{v:1'b1, ch:3'd3, d:16'd7,      e:1'b1, s:1'b0, hold:3};
    vecs[5]  = '{v:1'b1, ch:3'd0, d:16'd5,      e:1'b1, s:1'b0, hold:10};
    vecs[6]  = '{v:1'b1, ch:3'd3, d:16'd2,      e:1'b1, s:1'b0, hold:0};
    vecs[7]  = '{v:1'b1, ch:3'd4, d:16'd9,      e:1'b1, s:1'b1, hold:6};
    vecs[8]  = '{v:1'b1, ch:3'd4, d:16'd1,      e:1'b0, s:1'b0, hold:2};
    vecs[9]  = '{v:1'b1, ch:3'd0, d:16'd4,      e:1'b1, s:1'b0, hold:6};
    vecs[10] = '{v:1'b1, ch:3'd0, d:16'd4,      e:1'b0, s:1'b0, hold:10};
    vecs[11] = '{v:1'b1, ch:3'd7, d:16'd4,      e:1'b1, s:1'b0, hold:2};
    vecs[12] = '{v:1'b1, ch:3'd5, d:16'd4,      e:1'b1, s:1'b0, hold:2};
    vecs[13] = '{v:1'b1, ch:3'd2, d:16'd1,      e:1'b1, s:1'b0, hold:4};

    reset = 1'b1; cfg_valid = 1'b1; cfg_channel = 3'd0; cfg_divisor = 16'd4;
    cfg_enable = 1'b1; sync_start = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check("reset_div_out", 32'(div_out), 32'(0));
    check("reset_active", 32'(active), 32'(0));
    check("reset_tick", 32'(period_tick), 32'(0));
    check("reset_ready", 32'(cfg_ready), 32'(0));
    reset = 1'b0;

    // ch0 D=4: pattern 1,1,0,0 and a tick every fourth cycle
    step_cycle(1'b1, 3'd0, 16'd4, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      obs_out[i]  = div_out[0];
      obs_tick[i] = period_tick[0];
      idle_cycles(1);
    end
    check("ch0_d4_pattern", 32'(obs_out), 32'h33);
    check("ch0_d4_ticks", 32'(obs_tick), 32'h11);

    for (int i = 0; i < 14; i++) begin
      step_cycle(vecs[i].v, vecs[i].ch, vecs[i].d, vecs[i].e, vecs[i].s);
      idle_cycles(vecs[i].hold);
    end

    // Asynchronous reset in the high phase of a channel with a pending update
    step_cycle(1'b1, 3'd4, 16'd8, 1'b1, 1'b0);
    step_cycle(1'b1, 3'd4, 16'd3, 1'b1, 1'b0);
    check("ch4_high_before_reset", 32'(div_out[4]), 32'(1));
    check("ch4_active_before_reset", 32'(active[4]), 32'(1));
    #2;
    reset = 1'b1;
    #1;
    check("async_div_out", 32'(div_out), 32'(0));
    check("async_active", 32'(active), 32'(0));
    check("async_tick", 32'(period_tick), 32'(0));
    check("async_ready", 32'(cfg_ready), 32'(0));
    model_reset();
    @(posedge clock);
    #1;
    check("held_div_out", 32'(div_out), 32'(0));
    reset = 1'b0;

    cfg_valid = 1'b1; cfg_channel = 3'd5;
    #1;
    check("ch5_out_of_range_ready", 32'(cfg_ready), 32'(0));
    step_cycle(1'b1, 3'd5, 16'd4, 1'b1, 1'b0);
    idle_cycles(2);
    step_cycle(1'b1, 3'd4, 16'd4, 1'b1, 1'b0);
    idle_cycles(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/programmable_clock_divider_bank.md
Name: programmable_clock_divider_bank

Overview:
Bank of NUM_CHANNELS independent clock dividers, all driven from the single fabric `clock`. Each channel produces a registered divided-clock output with a runtime-programmable divisor loaded through a valid/ready config port. Divisor changes are glitch-free because they are applied only at period boundaries. A global sync_start phase-aligns all running channels. This generalises the fixed five-output clock block to N channels with programmable ratios and phase control.

Parameters:
NUM_CHANNELS, 5, number of divider channels (1..32)
DIV_WIDTH, 16, width of divisor and per-channel counter
CH_WIDTH, max(1,$clog2(NUM_CHANNELS)), width of channel index (derived, not overridden)

Ports:
clock  in  1  sole clock; all state on rising edge
reset  in  1  asynchronous, active-high; clears all state immediately
cfg_valid  in  1  config request
cfg_ready  out  1  config can be accepted this cycle
cfg_channel  in  CH_WIDTH  target channel index
cfg_divisor  in  DIV_WIDTH  divisor D (output period in clock cycles)
cfg_enable  in  1  1 = run channel with D; 0 = stop channel
sync_start  in  1  realign all running channels to period start
div_out  out  NUM_CHANNELS  divided clocks, registered
active  out  NUM_CHANNELS  channel is in RUN or PENDING
period_tick  out  NUM_CHANNELS  one-cycle pulse on the first cycle of each period

Behaviour:
- Reset: all channels IDLE; count=0; D=2; div_out=0, active=0, period_tick=0, no pending; cfg_ready=0 while reset is high.
- Divisor rules: effective D = max(cfg_divisor,2). D=0 or 1 is clamped to 2. Counter runs 0..D-1 and then wraps. div_out=1 while count < ceil(D/2), otherwise 0. Odd D gives the longer high phase (D=3: 2 high, 1 low).
- Handshake: a transfer occurs when cfg_valid && cfg_ready at a rising edge.
- cfg_ready = !reset && !sync_start && !pending[cfg_channel] && (cfg_channel < NUM_CHANNELS). It is combinational on cfg_channel. An out-of-range channel is never accepted.
- Channel FSM states: IDLE, RUN, PENDING.
- IDLE, transfer with enable=1: at that edge, state becomes RUN, D is loaded, count=0, div_out=1, period_tick=1. Outputs are visible the cycle after the handshake cycle.
- IDLE, transfer with enable=0: accepted, no state change.
- RUN, transfer: shadow {D,enable} is stored and state becomes PENDING. The channel continues its current period unchanged.
- RUN/PENDING, at the edge where count==D-1:
  - PENDING with enable=1: load shadow D, count=0, div_out=1, period_tick=1, state RUN.
  - PENDING with enable=0: state IDLE, div_out=0, count=0, active=0.
  - RUN: normal wrap (count=0, div_out=1, period_tick=1).
- period_tick is registered and high only on the first cycle of each period, including the first cycle after start. It is 0 in IDLE.
- sync_start=1 at an edge: every RUN/PENDING channel applies its pending shadow if one exists, then restarts with count=0, div_out=1, period_tick=1. IDLE channels are unaffected.
  - sync_start takes priority over the natural wrap. No config transfer occurs in that cycle because cfg_ready=0.
- Simultaneous events:
  - A transfer to channel k and a wrap on channel k in the same cycle: the new config is stored as pending and applied at the next boundary, not the current one.
  - Other channels are independent.
- Reset mid-operation: all outputs drop to 0 asynchronously and pending updates are discarded. After reset deasserts, the next edge sees all channels IDLE.
- Counter never exceeds D-1. No wrap-around overflow is possible for any D up to 2^DIV_WIDTH-1.

Test Plan:
- Reset then program ch0 D=4 enable=1 -> from the next cycle, div_out[0] pattern is 1,1,0,0 repeating; period_tick[0] pulses every 4 cycles; active[0]=1.
- Program ch1 D=3 and ch2 D=0 -> ch1 pattern 1,1,0; ch2 clamped to D=2, pattern 1,0.
- ch0 running D=4, write D=6 mid-period -> cfg_ready for ch0 is low until the boundary; the current period completes as 4 cycles; the following periods are 6 cycles (3 high, 3 low) with no glitch.
- ch0 D=5 and ch3 D=7 running, pulse sync_start -> both show div_out=1 and period_tick=1 on the same cycle; ch3 pending D=2 is applied at sync.
- Write enable=0 to a running ch0 D=4 at count=1 -> div_out stays high through count 1, then low, low; at the boundary active[0]=0 and div_out[0] stays 0.
- Assert reset asynchronously mid-high-phase with one channel pending -> div_out, active and period_tick go to 0 without waiting for a clock edge; after release, cfg_channel=5 (NUM_CHANNELS=5) gives cfg_ready=0.
